// File: rtl/irq_sched_pkg.sv
// Shared types, constants and helpers for the interrupt scheduler.
package irq_sched_pkg;

    localparam int unsigned IRQ_W    = 32;
    localparam int unsigned IRQ_ID_W = 5;

    localparam int unsigned IRQ_TIMER    = 0;
    localparam int unsigned IRQ_EBREAK   = 1;
    localparam int unsigned IRQ_BUSERROR = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2,
        DELAY  = 2'd3
    } irq_sched_state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [IRQ_ID_W-1:0] lowest_set(input logic [IRQ_W-1:0] v);
        logic [IRQ_ID_W-1:0] idx;
        idx = '0;
        for (int i = IRQ_W - 1; i >= 0; i--) begin
            if (v[i]) idx = IRQ_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_timer.sv
// Countdown timer feeding interrupt line 0; fire is a registered one-cycle pulse.
module irq_timer
    import irq_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IRQ_W-1:0] wdata,
    output logic [IRQ_W-1:0] value,
    output logic             fire
);

    // Load overrides both the decrement and the 1->0 fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
            fire  <= 1'b0;
        end else if (we) begin
            value <= wdata;
            fire  <= 1'b0;
        end else begin
            fire <= (value == IRQ_W'(1));
            if (value != '0) value <= value - IRQ_W'(1);
        end
    end

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: pending/mask handling, one-at-a-time entry over req/ack,
// nesting blocked until return, one idle cycle before the next entry.
// Optional countdown timer on line 0 is built when IRQ_SCHED_TIMER_EN is defined.
module irq_sched
    import irq_sched_pkg::*;
#(
    parameter logic [IRQ_W-1:0] LATCHED_IRQ = 32'hffff_ffff,
    parameter logic [IRQ_W-1:0] MASKED_IRQ  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IRQ_W-1:0]    irq,
    input  logic                decoder_trigger,
    input  logic                mask_we,
    input  logic [IRQ_W-1:0]    mask_wdata,
    output logic [IRQ_W-1:0]    mask_rdata,
    input  logic                timer_we,
    input  logic [IRQ_W-1:0]    timer_wdata,
    output logic [IRQ_W-1:0]    timer_rdata,
    output logic                irq_req,
    input  logic                irq_ack,
    output logic [IRQ_W-1:0]    irq_pending_q,
    output logic [IRQ_ID_W-1:0] irq_id,
    input  logic                irq_ret,
    output logic                irq_active,
    output logic [IRQ_W-1:0]    eoi
);

    irq_sched_state_t state;
    logic [IRQ_W-1:0] pend;
    logic [IRQ_W-1:0] pend_n;
    logic [IRQ_W-1:0] clr;
    logic [IRQ_W-1:0] avail;
    logic             timer_fire;

`ifdef IRQ_SCHED_TIMER_EN
    irq_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .we    (timer_we),
        .wdata (timer_wdata),
        .value (timer_rdata),
        .fire  (timer_fire)
    );
`else
    logic unused_timer;
    assign unused_timer = ^{timer_we, timer_wdata};
    assign timer_rdata  = '0;
    assign timer_fire   = 1'b0;
`endif

    // Serviced bits are cleared as the core accepts the entry.
    assign clr   = (state == REQ && irq_ack) ? irq_pending_q : '0;
    assign avail = pend & ~mask_rdata;

    // Next pending: latched lines are sticky, level lines follow input; set beats clear.
    always_comb begin
        pend_n            = ((pend & ~clr) & LATCHED_IRQ) | irq;
        pend_n[IRQ_TIMER] = pend_n[IRQ_TIMER] | timer_fire;
        pend_n            = pend_n & ~MASKED_IRQ;
    end

    // Pending register.
    always_ff @(posedge clk) begin
        if (reset) pend <= '0;
        else       pend <= pend_n;
    end

    // Software mask, writable in any state.
    always_ff @(posedge clk) begin
        if (reset)        mask_rdata <= '1;
        else if (mask_we) mask_rdata <= mask_wdata;
    end

    // Entry/exit sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            irq_req       <= 1'b0;
            irq_active    <= 1'b0;
            eoi           <= '0;
            irq_pending_q <= '0;
            irq_id        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (decoder_trigger && |avail) begin
                        state         <= REQ;
                        irq_req       <= 1'b1;
                        irq_pending_q <= avail;
                        irq_id        <= lowest_set(avail);
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state      <= ACTIVE;
                        irq_req    <= 1'b0;
                        irq_active <= 1'b1;
                        eoi        <= irq_pending_q;
                    end
                end
                ACTIVE: begin
                    if (irq_ret) begin
                        state      <= DELAY;
                        irq_active <= 1'b0;
                        eoi        <= '0;
                    end
                end
                DELAY: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_sched.sv
// Directed self-checking bench for irq_sched (bit 0 level, bit 31 hard-masked).
module tb_irq_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] irq;
    logic        decoder_trigger;
    logic        mask_we;
    logic [31:0] mask_wdata;
    logic [31:0] mask_rdata;
    logic        timer_we;
    logic [31:0] timer_wdata;
    logic [31:0] timer_rdata;
    logic        irq_req;
    logic        irq_ack;
    logic [31:0] irq_pending_q;
    logic [4:0]  irq_id;
    logic        irq_ret;
    logic        irq_active;
    logic [31:0] eoi;

    int n_checks = 0;
    int n_fail   = 0;

    irq_sched #(
        .LATCHED_IRQ (32'hffff_fffe),
        .MASKED_IRQ  (32'h8000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .irq             (irq),
        .decoder_trigger (decoder_trigger),
        .mask_we         (mask_we),
        .mask_wdata      (mask_wdata),
        .mask_rdata      (mask_rdata),
        .timer_we        (timer_we),
        .timer_wdata     (timer_wdata),
        .timer_rdata     (timer_rdata),
        .irq_req         (irq_req),
        .irq_ack         (irq_ack),
        .irq_pending_q   (irq_pending_q),
        .irq_id          (irq_id),
        .irq_ret         (irq_ret),
        .irq_active      (irq_active),
        .eoi             (eoi)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        n_checks++; if (mask_rdata !== 32'hffff_ffff) begin n_fail++; $display("FAIL rst_mask: got %h want ffffffff", mask_rdata); end
        n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", irq_req); end
        n_checks++; if (eoi !== 32'h0) begin n_fail++; $display("FAIL rst_eoi: got %h want 0", eoi); end
        n_checks++; if (irq_active !== 1'b0) begin n_fail++; $display("FAIL rst_active: got %b want 0", irq_active); end
        n_checks++; if (irq_pending_q !== 32'h0) begin n_fail++; $display("FAIL rst_pq: got %h want 0", irq_pending_q); end
        n_checks++; if (irq_id !== 5'd0) begin n_fail++; $display("FAIL rst_id: got %0d want 0", irq_id); end
        n_checks++; if (timer_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_timer: got %h want 0", timer_rdata); end
        irq = 32'h4;
        decoder_trigger = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL rst_masked_req[%0d]: got %b want 0", i, irq_req); end
        end
        irq = '0;
        decoder_trigger = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        mask_we = 1'b1; mask_wdata = 32'h0;
        tick;
        mask_we = 1'b0;
        n_checks++; if (mask_rdata !== 32'h0) begin n_fail++; $display("FAIL basic_mask: got %h want 0", mask_rdata); end
        irq = 32'h20;
        tick;
        irq = '0; decoder_trigger = 1'b1;
        tick;
        n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %b want 1", irq_req); end
        n_checks++; if (irq_id !== 5'd5) begin n_fail++; $display("FAIL basic_id: got %0d want 5", irq_id); end
        n_checks++; if (irq_pending_q !== 32'h20) begin n_fail++; $display("FAIL basic_pq: got %h want 20", irq_pending_q); end
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0;
        n_checks++; if (eoi !== 32'h20) begin n_fail++; $display("FAIL basic_eoi: got %h want 20", eoi); end
        n_checks++; if (irq_active !== 1'b1) begin n_fail++; $display("FAIL basic_active: got %b want 1", irq_active); end
        n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_drop: got %b want 0", irq_req); end
        irq_ret = 1'b1;
        tick;
        irq_ret = 1'b0;
        n_checks++; if (irq_active !== 1'b0) begin n_fail++; $display("FAIL basic_ret_active: got %b want 0", irq_active); end
        n_checks++; if (eoi !== 32'h0) begin n_fail++; $display("FAIL basic_ret_eoi: got %h want 0", eoi); end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL basic_cleared_req[%0d]: got %b want 0", i, irq_req); end
        end
        decoder_trigger = 1'b0;
    endtask

    task automatic test_priority();
        tick;
        irq = 32'h208;
        tick;
        irq = '0; decoder_trigger = 1'b1;
        tick;
        n_checks++; if (irq_id !== 5'd3) begin n_fail++; $display("FAIL prio_id: got %0d want 3", irq_id); end
        n_checks++; if (irq_pending_q !== 32'h208) begin n_fail++; $display("FAIL prio_pq: got %h want 208", irq_pending_q); end
        irq = 32'h2;
        tick;
        irq = '0;
        n_checks++; if (irq_pending_q !== 32'h208) begin n_fail++; $display("FAIL prio_freeze_pq: got %h want 208", irq_pending_q); end
        n_checks++; if (irq_id !== 5'd3) begin n_fail++; $display("FAIL prio_freeze_id: got %0d want 3", irq_id); end
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0;
        n_checks++; if (eoi !== 32'h208) begin n_fail++; $display("FAIL prio_eoi: got %h want 208", eoi); end
        tick;
        n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL prio_nonest: got %b want 0", irq_req); end
        irq_ret = 1'b1;
        tick;
        irq_ret = 1'b0;
        n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL prio_delay1_req: got %b want 0", irq_req); end
        tick;
        n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL prio_delay2_req: got %b want 0", irq_req); end
        tick;
        n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL prio_second_req: got %b want 1", irq_req); end
        n_checks++; if (irq_id !== 5'd1) begin n_fail++; $display("FAIL prio_second_id: got %0d want 1", irq_id); end
        n_checks++; if (irq_pending_q !== 32'h2) begin n_fail++; $display("FAIL prio_second_pq: got %h want 2", irq_pending_q); end
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0; irq_ret = 1'b1;
        tick;
        irq_ret = 1'b0;
        tick; tick;
        decoder_trigger = 1'b0;
    endtask

    task automatic test_level();
        tick;
        irq = 32'h1;
        tick; tick;
        irq = '0;
        tick;
        decoder_trigger = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL level_drop_req[%0d]: got %b want 0", i, irq_req); end
        end
        irq = 32'h1;
        tick; tick;
        n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL level_held_req: got %b want 1", irq_req); end
        n_checks++; if (irq_pending_q !== 32'h1) begin n_fail++; $display("FAIL level_held_pq: got %h want 1", irq_pending_q); end
        irq = '0; irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0; irq_ret = 1'b1;
        tick;
        irq_ret = 1'b0;
        tick; tick;
        decoder_trigger = 1'b0;
    endtask

    task automatic test_masked();
        tick;
        irq = 32'h8000_0000;
        tick;
        irq = '0; decoder_trigger = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL hardmask_req[%0d]: got %b want 0", i, irq_req); end
        end
        decoder_trigger = 1'b0; mask_we = 1'b1; mask_wdata = 32'h40;
        tick;
        mask_we = 1'b0;
        n_checks++; if (mask_rdata !== 32'h40) begin n_fail++; $display("FAIL swmask_rdata: got %h want 40", mask_rdata); end
        irq = 32'h40;
        tick;
        irq = '0; decoder_trigger = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL swmask_req[%0d]: got %b want 0", i, irq_req); end
        end
        mask_we = 1'b1; mask_wdata = 32'h0;
        tick;
        mask_we = 1'b0;
        n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL swmask_unmask_edge: got %b want 0", irq_req); end
        tick;
        n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL swmask_sticky_req: got %b want 1", irq_req); end
        n_checks++; if (irq_id !== 5'd6) begin n_fail++; $display("FAIL swmask_sticky_id: got %0d want 6", irq_id); end
        n_checks++; if (irq_pending_q !== 32'h40) begin n_fail++; $display("FAIL swmask_sticky_pq: got %h want 40", irq_pending_q); end
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0; irq_ret = 1'b1;
        tick;
        irq_ret = 1'b0;
        tick; tick;
        decoder_trigger = 1'b0;
    endtask

    task automatic test_timer();
`ifdef IRQ_SCHED_TIMER_EN
        tick;
        timer_we = 1'b1; timer_wdata = 32'd3;
        tick;
        timer_we = 1'b0;
        n_checks++; if (timer_rdata !== 32'd3) begin n_fail++; $display("FAIL timer_load: got %0d want 3", timer_rdata); end
        tick;
        n_checks++; if (timer_rdata !== 32'd2) begin n_fail++; $display("FAIL timer_dec2: got %0d want 2", timer_rdata); end
        tick;
        n_checks++; if (timer_rdata !== 32'd1) begin n_fail++; $display("FAIL timer_dec1: got %0d want 1", timer_rdata); end
        tick;
        n_checks++; if (timer_rdata !== 32'd0) begin n_fail++; $display("FAIL timer_zero: got %0d want 0", timer_rdata); end
        decoder_trigger = 1'b1;
        tick;
        n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL timer_early_req: got %b want 0", irq_req); end
        tick;
        n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL timer_fire_req: got %b want 1", irq_req); end
        n_checks++; if (irq_pending_q !== 32'h1) begin n_fail++; $display("FAIL timer_fire_pq: got %h want 1", irq_pending_q); end
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0; irq_ret = 1'b1;
        tick;
        irq_ret = 1'b0;
        tick; tick;
        n_checks++; if (timer_rdata !== 32'd0) begin n_fail++; $display("FAIL timer_stays_zero: got %0d want 0", timer_rdata); end
        timer_we = 1'b1; timer_wdata = 32'd2;
        tick;
        timer_we = 1'b0;
        tick;
        n_checks++; if (timer_rdata !== 32'd1) begin n_fail++; $display("FAIL timer_reload_one: got %0d want 1", timer_rdata); end
        timer_we = 1'b1; timer_wdata = 32'd5;
        tick;
        timer_we = 1'b0;
        n_checks++; if (timer_rdata !== 32'd5) begin n_fail++; $display("FAIL timer_override: got %0d want 5", timer_rdata); end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++; if (timer_rdata !== 32'(4 - i)) begin n_fail++; $display("FAIL timer_after_override[%0d]: got %0d want %0d", i, timer_rdata, 4 - i); end
            n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL timer_nofire_req[%0d]: got %b want 0", i, irq_req); end
        end
        timer_we = 1'b1; timer_wdata = 32'd0;
        tick;
        timer_we = 1'b0;
        decoder_trigger = 1'b0;
`else
        tick;
        timer_we = 1'b1; timer_wdata = 32'd3;
        tick;
        timer_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (timer_rdata !== 32'd0) begin n_fail++; $display("FAIL notimer_rdata[%0d]: got %0d want 0", i, timer_rdata); end
            tick;
        end
`endif
    endtask

    task automatic test_reset_active();
        tick;
        irq = 32'h10;
        tick;
        irq = '0; decoder_trigger = 1'b1;
        tick;
        n_checks++; if (irq_id !== 5'd4) begin n_fail++; $display("FAIL rsta_id: got %0d want 4", irq_id); end
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0;
        n_checks++; if (irq_active !== 1'b1) begin n_fail++; $display("FAIL rsta_active: got %b want 1", irq_active); end
        irq = 32'h80;
        tick;
        irq = '0; reset = 1'b1;
        tick;
        reset = 1'b0;
        n_checks++; if (irq_active !== 1'b0) begin n_fail++; $display("FAIL rsta_active_clr: got %b want 0", irq_active); end
        n_checks++; if (eoi !== 32'h0) begin n_fail++; $display("FAIL rsta_eoi_clr: got %h want 0", eoi); end
        n_checks++; if (irq_pending_q !== 32'h0) begin n_fail++; $display("FAIL rsta_pq_clr: got %h want 0", irq_pending_q); end
        n_checks++; if (mask_rdata !== 32'hffff_ffff) begin n_fail++; $display("FAIL rsta_mask: got %h want ffffffff", mask_rdata); end
        irq_ret = 1'b1;
        tick;
        irq_ret = 1'b0;
        n_checks++; if (irq_active !== 1'b0) begin n_fail++; $display("FAIL rsta_ret_ignored: got %b want 0", irq_active); end
        n_checks++; if (eoi !== 32'h0) begin n_fail++; $display("FAIL rsta_ret_eoi: got %h want 0", eoi); end
        mask_we = 1'b1; mask_wdata = 32'h0;
        tick;
        mask_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL rsta_pend_lost[%0d]: got %b want 0", i, irq_req); end
        end
        decoder_trigger = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq = '0; decoder_trigger = 1'b0;
        mask_we = 1'b0; mask_wdata = '0;
        timer_we = 1'b0; timer_wdata = '0;
        irq_ack = 1'b0; irq_ret = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_level();
        test_masked();
        test_timer();
        test_reset_active();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_sched.md
# irq_sched

Interrupt scheduler between the 32 external `irq` lines and the core's IRQ entry/exit sequencing. It latches or samples each line, applies the fixed and software masks, and runs the optional countdown timer on line 0. It arbitrates one request at a time to the core over a req/ack handshake, and reports the serviced bitmap on `eoi`. It blocks nesting until the core signals return, and then enforces a one-cycle delay before the next entry.

## Interface
Parameters:
- `LATCHED_IRQ`, 32'hffff_ffff: bit set = edge/latched line (sticky pending); bit clear = level line (pending follows input).
- `MASKED_IRQ`, 32'h0000_0000: bit set = line permanently ignored; pending bit forced 0.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `irq` in 32: external interrupt lines.
- `decoder_trigger` in 1: core at instruction boundary; entry permitted only when high.
- `mask_we` in 1, `mask_wdata` in 32: software mask write (bit set = masked).
- `mask_rdata` out 32: current mask.
- `timer_we` in 1, `timer_wdata` in 32: timer load.
- `timer_rdata` out 32: current timer value.
- `irq_req` out 1: interrupt entry request to core.
- `irq_ack` in 1: core accepts entry (writes q0/q1, jumps to PROGADDR_IRQ).
- `irq_pending_q` out 32: snapshot of serviced bits, for the core's q1 write.
- `irq_id` out 5: lowest set index of the snapshot.
- `irq_ret` in 1: core executed return-from-IRQ.
- `irq_active` out 1: handler running.
- `eoi` out 32: serviced bitmap, held during the handler.

## Operation
- Pending register `pend`, 32 bits, updated every cycle. For each bit i:
  - latched line (LATCHED_IRQ[i]=1): `pend_n[i] = (pend[i] & ~clr[i]) | irq[i]`
  - level line (LATCHED_IRQ[i]=0): `pend_n[i] = irq[i]`
  - Bit 0 is additionally set by a timer fire.
  - Finally `pend_n &= ~MASKED_IRQ`.
  - Set wins over clear in the same cycle.
- `avail = pend & ~mask`.
- State machine, states IDLE, REQ, ACTIVE, DELAY:
  - IDLE → REQ when `decoder_trigger && |avail`. On the transition: `irq_pending_q <= avail`; `irq_id <=` lowest set index of `avail`.
  - REQ: `irq_req`=1. `irq_pending_q` and `irq_id` stay frozen, even if pending or mask changes. On `irq_ack`: `clr = irq_pending_q`, `eoi <= irq_pending_q`, go to ACTIVE.
  - ACTIVE: `irq_active`=1 and no new request is raised. On `irq_ret`: `eoi <= 0`, go to DELAY.
  - DELAY: one cycle, then IDLE.
- Mask: written whenever `mask_we`=1, in any state. Resets to all ones.
- Timer: 32-bit down counter.
  - Decrements when nonzero.
  - A 1→0 transition fires (sets `pend[0]` next cycle); 0 stays 0 with no fire.
  - `timer_we` loads `timer_wdata` and overrides both the decrement and the fire that cycle.
- `irq_ack` outside REQ and `irq_ret` outside ACTIVE are ignored.

## Timing
- Reset values: `irq_req`=0, `irq_active`=0, `eoi`=0, `irq_pending_q`=0, `irq_id`=0, `mask_rdata`=32'hffff_ffff, `timer_rdata`=0. Internally `pend`=0 and state=IDLE.
- `irq` edge to `pend`: 1 cycle.
- `decoder_trigger` to `irq_req`: 1 cycle (registered).
- `irq_ack` to `irq_active`/`eoi` valid: 1 cycle.
- After `irq_ret`: `eoi` and `irq_active` drop the next cycle. The earliest new `irq_req` is 2 cycles after `irq_ret` (DELAY, then IDLE sampling).
- `reset` mid-handshake returns to IDLE immediately. Pending latched bits are lost.

## Configuration
- `IRQ_SCHED_TIMER_EN` defined: timer present as above.
- Not defined:
  - No timer logic.
  - `timer_rdata` tied to 0.
  - `timer_we` ignored.
  - Bit 0 behaves as an ordinary external line.

## Structure
- Package `irq_sched_pkg`:
  - state enum `irq_sched_state_t` (IDLE, REQ, ACTIVE, DELAY);
  - constants `IRQ_TIMER`=0, `IRQ_EBREAK`=1, `IRQ_BUSERROR`=2;
  - 32-bit width constant.
- Sub-module `irq_timer` (counter + fire pulse), instantiated only under `IRQ_SCHED_TIMER_EN`.
- Priority encoder is a package function.

## Test plan
- Reset: pulse `reset` → `mask_rdata`=ffff_ffff; `irq_req`, `eoi`, `irq_active` all 0. `irq`=32'h4 with mask all ones → no `irq_req`.
- Basic entry: write mask 0, pulse `irq[5]` one cycle, hold `decoder_trigger` → `irq_req`=1, `irq_id`=5, `irq_pending_q`=32'h20. Assert `irq_ack` → next cycle `eoi`=32'h20, `irq_active`=1, pending bit 5 clear.
- Priority and freeze: `irq[3]` and `irq[9]` together → `irq_id`=3, snapshot 32'h208. Raise `irq[1]` while in REQ → snapshot unchanged. After `irq_ret` plus the delay cycle, the second request shows `irq_id`=1.
- Level line: LATCHED_IRQ=32'hfffffffe, `irq[0]` high 2 cycles then low before the trigger → no request.
- Timer: with `IRQ_SCHED_TIMER_EN`, load 3 → `pend[0]` set 4 cycles later, `timer_rdata`=0. Load 1 in the same cycle it would hit 0 → no fire.
- Reset in ACTIVE: assert `reset` → `irq_active`=0 and `eoi`=0 the next cycle. A subsequent `irq_ret` is ignored.
